// File: rtl/dcache_responder_pkg.sv
// Shared widths, FSM state encoding and address-field helpers for the data cache.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package dcache_responder_pkg;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 16;
    localparam int INDEX_W  = 6;
    localparam int OFFSET_W = 2;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINE_W   = DATA_W << OFFSET_W;
    localparam int LADDR_W  = ADDR_W - OFFSET_W;
    localparam int NLINES   = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRBACK = 2'd1,
        ALLOC  = 2'd2
    } state_e;

    function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [OFFSET_W-1:0] get_offset(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W-1:0];
    endfunction

endpackage

// File: rtl/dcache_responder_if.sv
// CPU request port plus line-wide backing-memory port of the cache.
// Latency: wires only.
// Backpressure: rdy low stalls the CPU; mem_rdy completes a memory strobe.
interface dcache_responder_if;
    import dcache_responder_pkg::*;

    logic [ADDR_W-1:0]  addr;
    logic               re;
    logic               we;
    logic [DATA_W-1:0]  wdata;
    logic [DATA_W-1:0]  rdata;
    logic               rdy;
    logic [LADDR_W-1:0] mem_addr;
    logic               mem_re;
    logic               mem_we;
    logic [LINE_W-1:0]  mem_wdata;
    logic [LINE_W-1:0]  mem_rdata;
    logic               mem_rdy;

    // cache side
    modport slave (
        input  addr, re, we, wdata, mem_rdata, mem_rdy,
        output rdata, rdy, mem_addr, mem_re, mem_we, mem_wdata
    );

    // CPU + memory side
    modport master (
        output addr, re, we, wdata, mem_rdata, mem_rdy,
        input  rdata, rdy, mem_addr, mem_re, mem_we, mem_wdata
    );

endinterface

// File: rtl/dcache_responder_line_array.sv
// Valid/dirty/tag/data storage for the direct-mapped cache, one read port by index.
// Latency: combinational read; line and word writes land on the clock edge.
// Backpressure: none; the controller never asserts both write ports together.
module dcache_responder_line_array
    import dcache_responder_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INDEX_W-1:0]  i_rd_index,
    output logic                o_rd_valid,
    output logic                o_rd_dirty,
    output logic [TAG_W-1:0]    o_rd_tag,
    output logic [LINE_W-1:0]   o_rd_line,
    input  logic                i_lw_en,
    input  logic [INDEX_W-1:0]  i_lw_index,
    input  logic [TAG_W-1:0]    i_lw_tag,
    input  logic [LINE_W-1:0]   i_lw_line,
    input  logic                i_ww_en,
    input  logic [INDEX_W-1:0]  i_ww_index,
    input  logic [OFFSET_W-1:0] i_ww_offset,
    input  logic [DATA_W-1:0]   i_ww_data
);

    logic [NLINES-1:0] r_valid;
    logic [NLINES-1:0] r_dirty;
    logic [TAG_W-1:0]  r_tag  [NLINES];
    logic [LINE_W-1:0] r_line [NLINES];

    // Status bits: fill makes a line valid and clean, a word write makes it dirty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_lw_en) begin
            r_valid[i_lw_index] <= 1'b1;
            r_dirty[i_lw_index] <= 1'b0;
        end else if (i_ww_en) begin
            r_dirty[i_ww_index] <= 1'b1;
        end
    end

    // Tag and data payload; contents are meaningless while the valid bit is clear.
    always_ff @(posedge clk) begin
        if (i_lw_en) begin
            r_tag[i_lw_index]  <= i_lw_tag;
            r_line[i_lw_index] <= i_lw_line;
        end else if (i_ww_en) begin
            r_line[i_ww_index][int'(i_ww_offset)*DATA_W +: DATA_W] <= i_ww_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_dirty = r_dirty[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_line  = r_line[i_rd_index];

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-back write-allocate cache; DCACHE_STATS_EN adds hit_cnt/miss_cnt outputs.
// Latency: hits complete in the request cycle; misses take writeback (if dirty) + fill + one hit cycle.
// Backpressure: rdy drops for the whole miss; each memory strobe holds until mem_rdy.
module dcache_responder
    import dcache_responder_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    dcache_responder_if.slave   bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]         hit_cnt,
    output logic [15:0]         miss_cnt
`endif
);

    state_e              r_state;
    state_e              w_next;
    logic [TAG_W-1:0]    r_miss_tag;
    logic [INDEX_W-1:0]  r_miss_index;

    logic [TAG_W-1:0]    w_tag;
    logic [INDEX_W-1:0]  w_index;
    logic [OFFSET_W-1:0] w_offset;
    logic [INDEX_W-1:0]  w_rd_index;
    logic                w_req;
    logic                w_hit;
    logic                w_miss_start;
    logic                w_lw_en;
    logic                w_ww_en;
    logic                w_arr_valid;
    logic                w_arr_dirty;
    logic [TAG_W-1:0]    w_arr_tag;
    logic [LINE_W-1:0]   w_arr_line;
    logic [DATA_W-1:0]   w_word;

    assign w_tag    = get_tag(bus.addr);
    assign w_index  = get_index(bus.addr);
    assign w_offset = get_offset(bus.addr);
    assign w_req    = bus.re | bus.we;

    // Outside IDLE the array must keep pointing at the line being replaced,
    // even if the CPU has since dropped or changed its request.
    assign w_rd_index = (r_state == IDLE) ? w_index : r_miss_index;
    assign w_hit      = w_arr_valid && (w_arr_tag == w_tag);
    assign w_word     = w_arr_line[int'(w_offset)*DATA_W +: DATA_W];

    dcache_responder_line_array u_array (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rd_index  (w_rd_index),
        .o_rd_valid  (w_arr_valid),
        .o_rd_dirty  (w_arr_dirty),
        .o_rd_tag    (w_arr_tag),
        .o_rd_line   (w_arr_line),
        .i_lw_en     (w_lw_en),
        .i_lw_index  (r_miss_index),
        .i_lw_tag    (r_miss_tag),
        .i_lw_line   (bus.mem_rdata),
        .i_ww_en     (w_ww_en),
        .i_ww_index  (w_index),
        .i_ww_offset (w_offset),
        .i_ww_data   (bus.wdata)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latch the missing line address so the fill completes even if the request goes away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_miss_tag   <= '0;
            r_miss_index <= '0;
        end else if (w_miss_start) begin
            r_miss_tag   <= w_tag;
            r_miss_index <= w_index;
        end
    end

    // Next state, CPU response and memory-port decode.
    always_comb begin
        w_next        = r_state;
        w_miss_start  = 1'b0;
        w_lw_en       = 1'b0;
        w_ww_en       = 1'b0;
        bus.rdy       = 1'b1;
        bus.rdata     = '0;
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (r_state)
            IDLE: begin
                if (w_req && !w_hit) begin
                    bus.rdy      = 1'b0;
                    w_miss_start = 1'b1;
                    w_next       = (w_arr_valid && w_arr_dirty) ? WRBACK : ALLOC;
                end else if (w_req) begin
                    w_ww_en = bus.we;
                    if (bus.re && !bus.we) begin
                        bus.rdata = w_word;
                    end
                end
            end
            WRBACK: begin
                bus.rdy       = 1'b0;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {w_arr_tag, r_miss_index};
                bus.mem_wdata = w_arr_line;
                if (bus.mem_rdy) begin
                    w_next = ALLOC;
                end
            end
            ALLOC: begin
                bus.rdy      = 1'b0;
                bus.mem_re   = 1'b1;
                bus.mem_addr = {r_miss_tag, r_miss_index};
                if (bus.mem_rdy) begin
                    w_lw_en = 1'b1;
                    w_next  = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    // Saturating hit/miss counters; a miss counts once when leaving IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (r_state == IDLE && w_req && w_hit && r_hit_cnt != 16'hFFFF) begin
                r_hit_cnt <= r_hit_cnt + 16'd1;
            end
            if (w_miss_start && r_miss_cnt != 16'hFFFF) begin
                r_miss_cnt <= r_miss_cnt + 16'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Bench for dcache_responder: per-line cache model plus backing-memory model, checked every cycle.
// Latency: stimulus steps one access per call, memory responds after a chosen number of cycles.
// Backpressure: the bench plays memory and holds mem_rdy low for the chosen latency.
module tb_dcache_responder;
    import dcache_responder_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dcache_responder_if bus();

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    dcache_responder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endfunction

    // ---------------- model ----------------
    bit          m_valid [NLINES];
    bit          m_dirty [NLINES];
    logic [7:0]  m_tag   [NLINES];
    logic [63:0] m_line  [NLINES];
    logic [63:0] bmem    [int];
    int          m_hits;
    int          m_misses;

    function automatic logic [63:0] bmem_get(input int la);
        if (bmem.exists(la)) return bmem[la];
        return {16'hC000 | 16'(la), 16'h8000 | 16'(la), 16'h4000 | 16'(la), 16'(la)};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NLINES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    // ---------------- expectations, checked every falling edge ----------------
    bit          e_on = 1'b0;
    string       e_lbl = "";
    bit          e_rdy, e_chk_str, e_mre, e_mwe, e_chk_rdata, e_chk_maddr, e_chk_mwd;
    logic [15:0] e_rdata;
    logic [13:0] e_maddr;
    logic [63:0] e_mwd;

    always @(negedge clk) begin
        if (e_on) begin
            chk({e_lbl, ".rdy"}, 64'(bus.rdy), 64'(e_rdy));
            if (e_chk_str) begin
                chk({e_lbl, ".mem_re"}, 64'(bus.mem_re), 64'(e_mre));
                chk({e_lbl, ".mem_we"}, 64'(bus.mem_we), 64'(e_mwe));
            end
            if (e_chk_rdata) chk({e_lbl, ".rdata"}, 64'(bus.rdata), 64'(e_rdata));
            if (e_chk_maddr) chk({e_lbl, ".mem_addr"}, 64'(bus.mem_addr), 64'(e_maddr));
            if (e_chk_mwd)   chk({e_lbl, ".mem_wdata"}, bus.mem_wdata, e_mwd);
        end
    end

    // One cycle in which the cache must answer the currently driven request (or idle).
    task automatic serve_cycle();
        logic [15:0] a;
        logic [15:0] wd;
        bit r, w, req;
        int idx, off;
        a = bus.addr; r = bus.re; w = bus.we; wd = bus.wdata;
        idx = int'(a[7:2]); off = int'(a[1:0]);
        req = r | w;
        e_on = 1'b1; e_rdy = 1'b1; e_chk_str = 1'b1; e_mre = 1'b0; e_mwe = 1'b0;
        e_chk_rdata = (r && !w) || !req;
        e_rdata     = req ? m_line[idx][off*16 +: 16] : 16'h0;
        e_chk_maddr = !req; e_maddr = '0;
        e_chk_mwd   = !req; e_mwd   = '0;
        if (req) m_hits++;
        else bus.mem_rdy = 1'b1;   // stray completion while idle must be ignored
        @(posedge clk); #1;
        bus.mem_rdy = 1'b0;
        if (req && w) begin
            m_line[idx][off*16 +: 16] = wd;
            m_dirty[idx] = 1'b1;
        end
    endtask

    // Full access: optional writeback + fill with `lat` wait cycles each, then the hit cycle.
    task automatic access(input string lbl, input logic [15:0] a, input bit r, input bit w,
                          input logic [15:0] wd, input int lat, input bit drop);
        int idx, la;
        logic [7:0] tg;
        e_lbl = lbl;
        bus.addr = a; bus.re = r; bus.we = w; bus.wdata = wd; bus.mem_rdy = 1'b0;
        idx = int'(a[7:2]); tg = a[15:8];
        if ((r || w) && !(m_valid[idx] && m_tag[idx] == tg)) begin
            m_misses++;
            e_on = 1'b1; e_rdy = 1'b0; e_chk_str = 1'b0; e_chk_rdata = 1'b0;
            e_chk_maddr = 1'b0; e_chk_mwd = 1'b0;
            @(posedge clk); #1;
            if (drop) begin
                bus.re = 1'b0; bus.we = 1'b0; bus.addr = 16'h0FFF;
            end
            if (m_valid[idx] && m_dirty[idx]) begin
                la = int'({m_tag[idx], 6'(idx)});
                for (int k = 0; k <= lat; k++) begin
                    bus.mem_rdy = (k == lat);
                    e_rdy = 1'b0; e_chk_str = 1'b1; e_mre = 1'b0; e_mwe = 1'b1;
                    e_chk_maddr = 1'b1; e_maddr = 14'(la);
                    e_chk_mwd = 1'b1; e_mwd = m_line[idx];
                    @(posedge clk); #1;
                end
                bmem[la] = m_line[idx];
            end
            la = int'({tg, 6'(idx)});
            for (int k = 0; k <= lat; k++) begin
                bus.mem_rdata = bmem_get(la);
                bus.mem_rdy = (k == lat);
                e_rdy = 1'b0; e_chk_str = 1'b1; e_mre = 1'b1; e_mwe = 1'b0;
                e_chk_maddr = 1'b1; e_maddr = 14'(la); e_chk_mwd = 1'b0;
                @(posedge clk); #1;
            end
            bus.mem_rdy  = 1'b0;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
            m_line[idx]  = bmem_get(la);
        end
        serve_cycle();
    endtask

    task automatic do_reset();
        e_on = 1'b0;
        rst_n = 1'b0;
        bus.re = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        bus.mem_rdy = 1'b0; bus.mem_rdata = '0;
        @(posedge clk); @(posedge clk); #1;
        model_clear();
        rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.addr = '0; bus.re = 1'b0; bus.we = 1'b0; bus.wdata = '0;
        bus.mem_rdy = 1'b0; bus.mem_rdata = '0;
        do_reset();

        // 1: idle after reset, then a cold read reaches ALLOC for line 0x004
        access("t1_idle", 16'h0000, 1'b0, 1'b0, 16'h0, 0, 1'b0);
        e_lbl = "t1_miss";
        bus.addr = 16'h0010; bus.re = 1'b1;
        e_on = 1'b1; e_rdy = 1'b0; e_chk_str = 1'b0; e_chk_rdata = 1'b0;
        e_chk_maddr = 1'b0; e_chk_mwd = 1'b0;
        @(posedge clk); #1;
        e_on = 1'b0;
        #1;
        chk("t1_mem_re", 64'(bus.mem_re), 64'd1);
        chk("t1_mem_we", 64'(bus.mem_we), 64'd0);
        chk("t1_mem_addr", 64'(bus.mem_addr), 64'h004);
        do_reset();

        // 2: cold fill of {D,C,B,A}, then a second word of the same line without memory traffic
        bmem[4] = 64'h4444_3333_2222_1111;
        access("t2_cold", 16'h0013, 1'b1, 1'b0, 16'h0, 3, 1'b0);
        access("t2_hit", 16'h0010, 1'b1, 1'b0, 16'h0, 0, 1'b0);
        chk("t2_pin_word3", 64'(m_line[4][63:48]), 64'h4444);

        // 3: write hit, read back
        access("t3_wr", 16'h0011, 1'b0, 1'b1, 16'hBEEF, 0, 1'b0);
        access("t3_rd", 16'h0011, 1'b1, 1'b0, 16'h0, 0, 1'b0);
        chk("t3_pin_line", m_line[4], 64'h4444_3333_BEEF_1111);
        chk("t3_pin_dirty", 64'(m_dirty[4]), 64'd1);

        // 4: conflicting read evicts the dirty line (writeback 0x004, fill 0x044)
        access("t4_evict", 16'h0111, 1'b1, 1'b0, 16'h0, 2, 1'b0);
        chk("t4_pin_wb", bmem[4], 64'h4444_3333_BEEF_1111);

        // 5: reset during ALLOC drops the strobes and leaves nothing installed
        e_lbl = "t5_miss";
        bus.addr = 16'h0212; bus.re = 1'b1;
        e_on = 1'b1; e_rdy = 1'b0; e_chk_str = 1'b0; e_chk_rdata = 1'b0;
        e_chk_maddr = 1'b0; e_chk_mwd = 1'b0;
        @(posedge clk); #1;
        e_on = 1'b0;
        #1;
        chk("t5_alloc_re", 64'(bus.mem_re), 64'd1);
        chk("t5_alloc_addr", 64'(bus.mem_addr), 64'h084);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_mem_re", 64'(bus.mem_re), 64'd0);
        chk("t5_rst_mem_we", 64'(bus.mem_we), 64'd0);
        bus.re = 1'b0;
        @(posedge clk); #1;
        model_clear();
        rst_n = 1'b1;
        access("t5_again", 16'h0111, 1'b1, 1'b0, 16'h0, 1, 1'b0);
        chk("t5_pin_refill", bmem_get(int'(14'h044)), 64'hC044_8044_4044_0044);

        // request dropped mid-miss: fill still lands and then hits
        access("drop", 16'h0320, 1'b1, 1'b0, 16'h0, 2, 1'b1);
        access("drop_hit", 16'h0320, 1'b1, 1'b0, 16'h0, 0, 1'b0);

        // write miss allocates then writes; evicting it writes back line 0x148
        access("wmiss", 16'h0520, 1'b0, 1'b1, 16'h1234, 1, 1'b0);
        access("wmiss_evict", 16'h0320, 1'b1, 1'b0, 16'h0, 1, 1'b0);
        chk("wmiss_pin_wb", 64'(bmem[int'(14'h148)][15:0]), 64'h1234);

        // re and we together: the write wins
        access("rw_both", 16'h0321, 1'b1, 1'b1, 16'h7777, 0, 1'b0);
        access("rw_read", 16'h0321, 1'b1, 1'b0, 16'h0, 0, 1'b0);
        access("idle_end", 16'h0000, 1'b0, 1'b0, 16'h0, 0, 1'b0);

`ifdef DCACHE_STATS_EN
        // 6: counters, then saturation of hit_cnt
        do_reset();
        access("s_miss", 16'h0010, 1'b1, 1'b0, 16'h0, 1, 1'b0);
        access("s_hit", 16'h0012, 1'b1, 1'b0, 16'h0, 0, 1'b0);
        e_on = 1'b0;
        bus.re = 1'b0;
        @(negedge clk);
        chk("s_hit_cnt", 64'(hit_cnt), 64'(m_hits));
        chk("s_miss_cnt", 64'(miss_cnt), 64'(m_misses));
        chk("s_pin_hits", 64'(hit_cnt), 64'd2);
        chk("s_pin_miss", 64'(miss_cnt), 64'd1);
        bus.re = 1'b1;
        repeat (65540) @(posedge clk);
        bus.re = 1'b0;
        @(negedge clk);
        chk("s_hit_sat", 64'(hit_cnt), 64'hFFFF);
        chk("s_miss_hold", 64'(miss_cnt), 64'd1);
`endif

        e_on = 1'b0;
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
